// File: rtl/pc_redirect_unit_pkg.sv
// pc_redirect_unit_pkg: shared reset PC, fetch FSM encoding and sequential PC step.
package pc_redirect_unit_pkg;
  localparam logic [31:0] RESET_PC_DEF = 32'h0000_3000;
  localparam int PC_STEP = 4;
  typedef enum logic [1:0] {S_BOOT, S_FETCH, S_WAIT} state_e;
endpackage

// File: rtl/pc_target_calc.sv
// pc_target_calc: combinational branch/j/jr target generation with jr > jump > branch priority.
module pc_target_calc
  import pc_redirect_unit_pkg::*;
#(
  parameter int ADDR_W = 32
) (
  input  logic [ADDR_W-1:0] id_pc_i,
  input  logic [15:0]       id_imm16_i,
  input  logic [25:0]       id_index_i,
  input  logic [ADDR_W-1:0] jr_target_i,
  input  logic              branch_i,
  input  logic              jump_i,
  input  logic              jr_i,
  output logic [ADDR_W-1:0] tgt_o,
  output logic              take_o,
  output logic              align_err_o
);
  logic [ADDR_W-1:0] p4, br_tgt, j_tgt, jr_tgt;
  assign p4     = id_pc_i + ADDR_W'(PC_STEP);
  assign br_tgt = p4 + {{(ADDR_W-18){id_imm16_i[15]}}, id_imm16_i, 2'b00};
  assign j_tgt  = {p4[ADDR_W-1:28], id_index_i, 2'b00};
  // jr drops the low bits rather than trapping; the misalignment is only flagged
  assign jr_tgt = {jr_target_i[ADDR_W-1:2], 2'b00};
  assign tgt_o       = jr_i ? jr_tgt : jump_i ? j_tgt : br_tgt;
  assign take_o      = jr_i | jump_i | branch_i;
  assign align_err_o = jr_i & |jr_target_i[1:0];
endmodule

// File: rtl/pc_redirect_unit.sv
// pc_redirect_unit: fetch PC sequencer with valid/ready imem requests and held redirects.
module pc_redirect_unit
  import pc_redirect_unit_pkg::*;
#(
  parameter int                ADDR_W   = 32,
  parameter logic [ADDR_W-1:0] RESET_PC = ADDR_W'(RESET_PC_DEF)
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              stall_i,
  input  logic              branch_i,
  input  logic              jump_i,
  input  logic              jr_i,
  input  logic [ADDR_W-1:0] id_pc_i,
  input  logic [15:0]       id_imm16_i,
  input  logic [25:0]       id_index_i,
  input  logic [ADDR_W-1:0] jr_target_i,
  output logic              req_valid_o,
  output logic [ADDR_W-1:0] req_addr_o,
  input  logic              req_ready_i,
  output logic [ADDR_W-1:0] pc_o,
  output logic              redirect_o,
  output logic              align_err_o
);
  state_e            state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d, pend_tgt_q, pend_tgt_d, tgt;
  logic              pend_v_q, pend_v_d, redirect_q, align_q;
  logic              take, tgt_align, sampled, accept;
  pc_target_calc #(.ADDR_W(ADDR_W)) u_calc (
    .id_pc_i    (id_pc_i),
    .id_imm16_i (id_imm16_i),
    .id_index_i (id_index_i),
    .jr_target_i(jr_target_i),
    .branch_i   (branch_i),
    .jump_i     (jump_i),
    .jr_i       (jr_i),
    .tgt_o      (tgt),
    .take_o     (take),
    .align_err_o(tgt_align)
  );
  // valid is decoded from state so an asserted reset drops the request immediately
  assign req_valid_o = state_q != S_BOOT;
  assign accept      = req_valid_o & req_ready_i & !stall_i;
  // stalled ID operands are stale, and a held redirect blocks newer ones
  assign sampled     = take & !stall_i & !pend_v_q;
  assign req_addr_o  = pc_q;
  assign pc_o        = pc_q;
  assign redirect_o  = redirect_q;
  assign align_err_o = align_q;
  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    pend_v_d   = pend_v_q;
    pend_tgt_d = pend_tgt_q;
    if (state_q == S_BOOT || accept) state_d = S_FETCH;
    else if (!req_ready_i) state_d = S_WAIT;
    if (accept) begin
      pc_d     = pend_v_q ? pend_tgt_q : sampled ? tgt : pc_q + ADDR_W'(PC_STEP);
      pend_v_d = 1'b0;
    end else if (sampled) begin
      pend_v_d   = 1'b1;
      pend_tgt_d = tgt;
    end
  end
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= S_BOOT;
      pc_q       <= RESET_PC;
      pend_v_q   <= 1'b0;
      pend_tgt_q <= '0;
      redirect_q <= 1'b0;
      align_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      pend_v_q   <= pend_v_d;
      pend_tgt_q <= pend_tgt_d;
      redirect_q <= accept & (pend_v_q | sampled);
      align_q    <= sampled & tgt_align;
    end
  end
endmodule

// File: tb/tb_pc_redirect_unit.sv
// tb_pc_redirect_unit: table-driven directed vectors plus a mid-WAIT reset sequence.
module tb_pc_redirect_unit;
  logic        clk = 1'b0;
  logic        reset_n, stall_i, branch_i, jump_i, jr_i, req_ready_i;
  logic [31:0] id_pc_i, jr_target_i, req_addr_o, pc_o;
  logic [15:0] id_imm16_i;
  logic [25:0] id_index_i;
  logic        req_valid_o, redirect_o, align_err_o;
  int          errors = 0;
  int          checks = 0;

  typedef struct {
    logic        stall, br, jmp, jr, ready;
    logic [31:0] id_pc;
    logic [15:0] imm;
    logic [25:0] idx;
    logic [31:0] jrt;
    logic        ev;
    logic [31:0] epc;
    logic        erd, eal;
  } vec_t;
  vec_t vecs[$];

  pc_redirect_unit dut (
    .clk(clk), .reset_n(reset_n), .stall_i(stall_i), .branch_i(branch_i),
    .jump_i(jump_i), .jr_i(jr_i), .id_pc_i(id_pc_i), .id_imm16_i(id_imm16_i),
    .id_index_i(id_index_i), .jr_target_i(jr_target_i), .req_valid_o(req_valid_o),
    .req_addr_o(req_addr_o), .req_ready_i(req_ready_i), .pc_o(pc_o),
    .redirect_o(redirect_o), .align_err_o(align_err_o)
  );

  always #5 clk = ~clk;

  task automatic add(input logic s, b, j, r, rdy, input logic [31:0] pc, input logic [15:0] imm,
                     input logic [25:0] idx, input logic [31:0] jrt, input logic ev,
                     input logic [31:0] epc, input logic erd, eal);
    vec_t v;
    v.stall = s; v.br = b; v.jmp = j; v.jr = r; v.ready = rdy;
    v.id_pc = pc; v.imm = imm; v.idx = idx; v.jrt = jrt;
    v.ev = ev; v.epc = epc; v.erd = erd; v.eal = eal;
    vecs.push_back(v);
  endtask

  task automatic chk(input string name, input logic [31:0] act, exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic chk_all(input string tag, input logic ev, input logic [31:0] epc, input logic erd, eal);
    chk({tag, " valid"}, {31'd0, req_valid_o}, {31'd0, ev});
    chk({tag, " pc"}, pc_o, epc);
    chk({tag, " addr"}, req_addr_o, epc);
    chk({tag, " redirect"}, {31'd0, redirect_o}, {31'd0, erd});
    chk({tag, " align"}, {31'd0, align_err_o}, {31'd0, eal});
  endtask

  task automatic drive(input vec_t v);
    stall_i = v.stall; branch_i = v.br; jump_i = v.jmp; jr_i = v.jr; req_ready_i = v.ready;
    id_pc_i = v.id_pc; id_imm16_i = v.imm; id_index_i = v.idx; jr_target_i = v.jrt;
  endtask

  initial begin
    //  st br j  jr rdy id_pc         imm       idx          jrt           ev epc           rd al
    add(0, 0, 0, 0, 1, 32'h0,        16'h0,    26'h0,       32'h0,        1, 32'h3000,     0, 0);
    add(0, 0, 0, 0, 1, 32'h0,        16'h0,    26'h0,       32'h0,        1, 32'h3004,     0, 0);
    add(0, 0, 0, 0, 1, 32'h0,        16'h0,    26'h0,       32'h0,        1, 32'h3008,     0, 0);
    add(0, 1, 0, 0, 1, 32'h3008,     16'hFFFF, 26'h0,       32'h0,        1, 32'h3008,     1, 0);
    add(0, 0, 0, 0, 1, 32'h0,        16'h0,    26'h0,       32'h0,        1, 32'h300C,     0, 0);
    add(0, 0, 1, 0, 0, 32'h300C,     16'h0,    26'h0000C10, 32'h0,        1, 32'h300C,     0, 0);
    add(0, 0, 0, 0, 0, 32'h0,        16'h0,    26'h0,       32'h0,        1, 32'h300C,     0, 0);
    add(0, 0, 0, 0, 0, 32'h0,        16'h0,    26'h0,       32'h0,        1, 32'h300C,     0, 0);
    add(0, 0, 0, 0, 1, 32'h0,        16'h0,    26'h0,       32'h0,        1, 32'h3040,     1, 0);
    add(0, 0, 0, 0, 1, 32'h0,        16'h0,    26'h0,       32'h0,        1, 32'h3044,     0, 0);
    add(1, 1, 0, 0, 1, 32'h3044,     16'h0010, 26'h0,       32'h0,        1, 32'h3044,     0, 0);
    add(1, 1, 0, 0, 1, 32'h3044,     16'h0010, 26'h0,       32'h0,        1, 32'h3044,     0, 0);
    add(0, 1, 0, 0, 1, 32'h3044,     16'h0010, 26'h0,       32'h0,        1, 32'h3088,     1, 0);
    add(0, 0, 0, 0, 1, 32'h0,        16'h0,    26'h0,       32'h0,        1, 32'h308C,     0, 0);
    add(0, 0, 0, 1, 1, 32'h0,        16'h0,    26'h0,       32'h3013,     1, 32'h3010,     1, 1);
    add(0, 0, 0, 0, 1, 32'h0,        16'h0,    26'h0,       32'h0,        1, 32'h3014,     0, 0);
    add(0, 0, 0, 1, 1, 32'h0,        16'h0,    26'h0,       32'hFFFF_FFFC, 1, 32'hFFFF_FFFC, 1, 0);
    add(0, 0, 0, 0, 1, 32'h0,        16'h0,    26'h0,       32'h0,        1, 32'h0,        0, 0);
    add(0, 1, 1, 1, 1, 32'h0,        16'h0001, 26'h3FFFFFF, 32'h4000,     1, 32'h4000,     1, 0);
    add(0, 0, 0, 0, 1, 32'h0,        16'h0,    26'h0,       32'h0,        1, 32'h4004,     0, 0);
    add(0, 1, 1, 0, 1, 32'h4004,     16'h0007, 26'h0000100, 32'h0,        1, 32'h0400,     1, 0);
    add(0, 0, 0, 0, 1, 32'h0,        16'h0,    26'h0,       32'h0,        1, 32'h0404,     0, 0);
    add(0, 1, 0, 0, 1, 32'h0,        16'h8000, 26'h0,       32'h0,        1, 32'hFFFE_0004, 1, 0);
    add(0, 0, 0, 0, 1, 32'h0,        16'h0,    26'h0,       32'h0,        1, 32'hFFFE_0008, 0, 0);
    add(0, 0, 1, 0, 0, 32'h0,        16'h0,    26'h0000010, 32'h0,        1, 32'hFFFE_0008, 0, 0);
    add(1, 0, 0, 0, 1, 32'h0,        16'h0,    26'h0,       32'h0,        1, 32'hFFFE_0008, 0, 0);
    add(0, 0, 0, 0, 1, 32'h0,        16'h0,    26'h0,       32'h0,        1, 32'h0040,     1, 0);
    add(0, 0, 0, 0, 1, 32'h0,        16'h0,    26'h0,       32'h0,        1, 32'h0044,     0, 0);

    reset_n = 1'b0;
    drive(vecs[1]);
    repeat (2) @(posedge clk);
    #1 chk_all("reset", 0, 32'h3000, 0, 0);
    reset_n = 1'b1;
    for (int i = 0; i < vecs.size(); i++) begin
      drive(vecs[i]);
      @(posedge clk);
      #1 chk_all($sformatf("vec%0d", i), vecs[i].ev, vecs[i].epc, vecs[i].erd, vecs[i].eal);
    end

    // reset asserted mid-cycle while a jump is held in WAIT
    stall_i = 0; branch_i = 0; jr_i = 0; jump_i = 1; id_pc_i = 0; id_index_i = 26'h0000C10; req_ready_i = 0;
    @(posedge clk);
    #1 chk_all("wait_hold", 1, 32'h0044, 0, 0);
    jump_i = 0;
    #3 reset_n = 1'b0;
    #1 chk_all("async_reset", 0, 32'h3000, 0, 0);
    @(posedge clk);
    #1 reset_n = 1'b1;
    req_ready_i = 1;
    @(posedge clk);
    #1 chk_all("post_reset1", 1, 32'h3000, 0, 0);
    @(posedge clk);
    #1 chk_all("post_reset2", 1, 32'h3004, 0, 0);
    @(posedge clk);
    #1 chk_all("post_reset3", 1, 32'h3008, 0, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
